// File: rtl/alu_input_sequencer_pkg.sv
// alu_input_sequencer_pkg
// Definitions shared by the operand-entry front end and the arithmetic unit it feeds:
//   DATA_W  - operand and result width
//   state_t - sequencer FSM states (the encoding is exported on state_dbg for LEDs)
//   op_t    - operator codes, identical to the arithmetic unit's op input
package alu_input_sequencer_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    SHOW    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_MUL  = 2'd2,
    OP_RSVD = 2'd3
  } op_t;

endpackage

// File: rtl/alu_input_sequencer_if.sv
// alu_input_sequencer_if
// Connection between the sequencer and the combinational arithmetic unit.
//   alu_a, alu_b : operands (two's complement)
//   alu_op       : operator code (op_t encoding)
//   alu_out      : combinational result from the arithmetic unit
//   alu_ovf      : combinational overflow flag from the arithmetic unit
// Modports:
//   master - the sequencer (drives the operands, reads the result)
//   slave  - the arithmetic unit
interface alu_input_sequencer_if;
  import alu_input_sequencer_pkg::*;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [1:0]        alu_op;
  logic [DATA_W-1:0] alu_out;
  logic              alu_ovf;

  modport master (
    output alu_a,
    output alu_b,
    output alu_op,
    input  alu_out,
    input  alu_ovf
  );

  modport slave (
    input  alu_a,
    input  alu_b,
    input  alu_op,
    output alu_out,
    output alu_ovf
  );
endinterface

// File: rtl/alu_input_sequencer_button_debouncer.sv
// button_debouncer
// Conditions a raw mechanical push-button and produces a single-cycle pulse
// on each accepted press.
//   clk, rst_n : clock and asynchronous active-low reset
//   btn        : raw, asynchronous, bouncy button level (active-high)
//   pulse      : one clk cycle high on each 0->1 edge of the debounced level
// A level change is accepted only after it has been stable for DEBOUNCE_CYC
// consecutive cycles, so a shorter glitch never reaches the debounced level.
module button_debouncer #(
  parameter int unsigned      CNT_W        = 20,
  parameter logic [CNT_W-1:0] DEBOUNCE_CYC = 20'd1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = DEBOUNCE_CYC - CNT_W'(1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             level_reg;
  logic             level_dly_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg     <= 1'b0;
      sync2_reg     <= 1'b0;
      level_reg     <= 1'b0;
      level_dly_reg <= 1'b0;
      cnt_reg       <= '0;
    end else begin
      sync1_reg     <= btn;
      sync2_reg     <= sync1_reg;
      level_dly_reg <= level_reg;
      // The counter only runs while the synchronized input disagrees with the
      // accepted level; any return to agreement restarts the stability window.
      if (sync2_reg != level_reg) begin
        if (cnt_reg == CNT_LAST) begin
          level_reg <= ~level_reg;
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  // Rising edge of the accepted level only; release produces nothing.
  assign pulse = level_reg & ~level_dly_reg;

endmodule

// File: rtl/alu_input_sequencer.sv
// alu_input_sequencer
// Operand-entry front end for the signed 8-bit arithmetic unit. One button
// steps through A, B and operator entry; the unit's combinational output is
// then captured into registered display outputs.
//   clk, rst_n    : clock, asynchronous active-low reset
//   sw            : operand value from switches
//   op_sw         : operator select (op_t encoding, 3 is passed through as-is)
//   btn_enter     : raw bouncy push-button
//   btn_clear     : clean synchronous clear, wins over a same-cycle enter
//   alu           : master side of the arithmetic unit connection
//   result        : captured result
//   result_ovf    : captured overflow flag
//   result_valid  : high while the captured result is being shown
//   state_dbg     : current FSM state encoding
module alu_input_sequencer
  import alu_input_sequencer_pkg::*;
#(
  parameter int unsigned      CNT_W        = 20,
  parameter logic [CNT_W-1:0] DEBOUNCE_CYC = 20'd1_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     sw,
  input  logic [1:0]            op_sw,
  input  logic                  btn_enter,
  input  logic                  btn_clear,
  alu_input_sequencer_if.master alu,
  output logic [DATA_W-1:0]     result,
  output logic                  result_ovf,
  output logic                  result_valid,
  output logic [2:0]            state_dbg
);

  logic enter_pulse;

  button_debouncer #(
    .CNT_W        (CNT_W),
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_debouncer (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_enter),
    .pulse (enter_pulse)
  );

  state_t            state_reg,  state_next;
  logic [DATA_W-1:0] a_reg,      a_next;
  logic [DATA_W-1:0] b_reg,      b_next;
  logic [1:0]        op_reg,     op_next;
  logic [DATA_W-1:0] result_reg, result_next;
  logic              ovf_reg,    ovf_next;
  logic              valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= LOAD_A;
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= 2'd0;
      result_reg <= '0;
      ovf_reg    <= 1'b0;
      valid_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      op_reg     <= op_next;
      result_reg <= result_next;
      ovf_reg    <= ovf_next;
      // Registered so the LED follows the state without a decode glitch.
      valid_reg  <= (state_next == SHOW);
    end
  end

  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    op_next     = op_reg;
    result_next = result_reg;
    ovf_next    = ovf_reg;

    if (btn_clear) begin
      // A coincident enter_pulse is deliberately swallowed here.
      state_next  = LOAD_A;
      result_next = '0;
      ovf_next    = 1'b0;
    end else begin
      unique case (state_reg)
        LOAD_A: begin
          if (enter_pulse) begin
            a_next     = sw;
            state_next = LOAD_B;
          end
        end
        LOAD_B: begin
          if (enter_pulse) begin
            b_next     = sw;
            state_next = LOAD_OP;
          end
        end
        LOAD_OP: begin
          if (enter_pulse) begin
            op_next    = op_sw;
            state_next = EXEC;
          end
        end
        EXEC: begin
          // Operands have been stable in registers for a full cycle, so the
          // combinational unit has settled by the time this edge samples it.
          result_next = alu.alu_out;
          ovf_next    = alu.alu_ovf;
          state_next  = SHOW;
        end
        SHOW: begin
          if (enter_pulse) begin
            state_next = LOAD_A;
          end
        end
        default: state_next = LOAD_A;
      endcase
    end
  end

  assign alu.alu_a    = a_reg;
  assign alu.alu_b    = b_reg;
  assign alu.alu_op   = op_reg;
  assign result       = result_reg;
  assign result_ovf   = ovf_reg;
  assign result_valid = valid_reg;
  assign state_dbg    = state_reg;

endmodule
